// File: rtl/router_reg_gen_if.sv
// router_reg_gen_if
//   Bundles the router register's FSM strobes, byte input and FIFO-side
//   outputs into one interface.
//   master : drives the byte stream and FSM strobes, observes d_out/status.
//   slave  : the router register itself.
// Signals
//   pkt_valid, data_in, fifo_full, rst_in_reg       byte stream / FIFO status
//   detect_add, lfd_state, ld_state, laf_state,
//   full_state                                      FSM state strobes
//   d_out, parity_done, low_pkt_valid, err,
//   len_err, ovf_err, skid_empty                    outputs toward FIFO / FSM
interface router_reg_gen_if #(
  parameter int DATA_W = 8
) ();
  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              rst_in_reg;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic [DATA_W-1:0] d_out;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;
  logic              len_err;
  logic              ovf_err;
  logic              skid_empty;

  modport master (
    output pkt_valid, data_in, fifo_full, rst_in_reg,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
    input  d_out, parity_done, low_pkt_valid, err, len_err, ovf_err, skid_empty
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, rst_in_reg,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
    output d_out, parity_done, low_pkt_valid, err, len_err, ovf_err, skid_empty
  );
endinterface

// File: rtl/router_reg_gen.sv
// router_reg_gen
//   Datapath register between the router FSM and the output FIFOs.
//   Captures the header, forwards payload bytes to d_out, accumulates an
//   XOR parity or additive checksum and compares it against the trailing
//   parity byte, checks the header length field and buffers up to
//   SKID_DEPTH bytes while the output FIFO is full.
// Ports
//   clk     : clock, all logic on posedge
//   resetn  : synchronous active-low reset
//   bus     : router_reg_gen_if.slave (byte stream, FSM strobes, outputs)
// Parameters
//   DATA_W      : byte width; header = {len[DATA_W-1:2], addr[1:0]}
//   SKID_DEPTH  : bytes held while fifo_full (>=1)
//   PARITY_MODE : 0 = XOR parity, 1 = sum mod 2^DATA_W
module router_reg_gen #(
  parameter int DATA_W      = 8,
  parameter int SKID_DEPTH  = 2,
  parameter int PARITY_MODE = 0
) (
  input logic              clk,
  input logic              resetn,
  router_reg_gen_if.slave  bus
);
  localparam int LEN_W = DATA_W - 2;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam logic [CNT_W-1:0] SKID_MAX = CNT_W'(SKID_DEPTH);

  // Skid entries carry the pkt_valid tag in the MSB so a buffered parity
  // byte can still raise parity_done when it is finally popped.
  typedef logic [DATA_W:0] skid_entry_t;

  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [DATA_W-1:0] chk_q, chk_d;
  logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              parity_done_q, parity_done_d;
  logic              low_pkt_valid_q, low_pkt_valid_d;
  logic              err_q, err_d;
  logic              len_err_q, len_err_d;
  logic              ovf_err_q, ovf_err_d;
  logic [CNT_W-1:0]  skid_cnt_q, skid_cnt_d;
  skid_entry_t       skid_mem_q [SKID_DEPTH];
  skid_entry_t       skid_mem_d [SKID_DEPTH];

  logic skid_empty;
  logic skid_full;
  logic accept;
  logic pd_set;

  function automatic logic [DATA_W-1:0] chk_upd(input logic [DATA_W-1:0] c,
                                                input logic [DATA_W-1:0] d);
    if (PARITY_MODE == 0) return c ^ d;
    else                  return c + d;
  endfunction

  // Byte counter saturates instead of wrapping so an over-long packet
  // can never alias back onto a matching length.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign skid_empty = (skid_cnt_q == '0);
  assign skid_full  = (skid_cnt_q == SKID_MAX);

  always_comb begin
    hdr_d           = hdr_q;
    chk_d           = chk_q;
    pkt_par_d       = pkt_par_q;
    byte_cnt_d      = byte_cnt_q;
    d_out_d         = d_out_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;
    len_err_d       = len_err_q;
    ovf_err_d       = ovf_err_q;
    skid_cnt_d      = skid_cnt_q;
    skid_mem_d      = skid_mem_q;
    accept          = 1'b0;
    pd_set          = 1'b0;

    if (bus.detect_add) begin
      if (bus.pkt_valid) hdr_d = bus.data_in;
      parity_done_d = 1'b0;
      pkt_par_d     = '0;
      chk_d         = '0;
      byte_cnt_d    = '0;
      len_err_d     = 1'b0;
      ovf_err_d     = 1'b0;
    end else if (bus.lfd_state) begin
      d_out_d    = hdr_q;
      chk_d      = hdr_q;
      byte_cnt_d = '0;
    end else if (bus.ld_state) begin
      // Once anything is buffered, new bytes queue behind it to keep order.
      if (!bus.fifo_full && skid_empty) begin
        d_out_d = bus.data_in;
        accept  = 1'b1;
        if (!bus.pkt_valid) pd_set = 1'b1;
      end else if (skid_full) begin
        ovf_err_d = 1'b1;
      end else begin
        for (int i = 0; i < SKID_DEPTH; i++) begin
          if (skid_cnt_q == CNT_W'(i)) skid_mem_d[i] = {bus.pkt_valid, bus.data_in};
        end
        skid_cnt_d = skid_cnt_q + 1'b1;
        accept     = 1'b1;
      end
      if (accept) begin
        if (bus.pkt_valid && !bus.full_state) begin
          chk_d      = chk_upd(chk_q, bus.data_in);
          byte_cnt_d = sat_inc(byte_cnt_q);
        end
        if (!bus.pkt_valid) begin
          pkt_par_d       = bus.data_in;
          low_pkt_valid_d = 1'b1;
        end
      end
    end else if (bus.laf_state && !skid_empty && !bus.fifo_full) begin
      // Head is always entry 0; popping shifts the rest down one slot.
      d_out_d = skid_mem_q[0][DATA_W-1:0];
      if (!skid_mem_q[0][DATA_W]) pd_set = 1'b1;
      for (int i = 0; i < SKID_DEPTH - 1; i++) begin
        skid_mem_d[i] = skid_mem_q[i+1];
      end
      skid_cnt_d = skid_cnt_q - 1'b1;
    end

    // Length is judged only on the rising edge of parity_done.
    if (pd_set) begin
      parity_done_d = 1'b1;
      if (!parity_done_q && (byte_cnt_q != hdr_q[DATA_W-1:2])) len_err_d = 1'b1;
    end

    // Soft reset overrides any set of low_pkt_valid in the same cycle.
    if (bus.rst_in_reg) begin
      low_pkt_valid_d = 1'b0;
      skid_cnt_d      = '0;
      if (!bus.pkt_valid) begin
        chk_d     = '0;
        pkt_par_d = '0;
      end
    end

    err_d = parity_done_q && (chk_q != pkt_par_q);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hdr_q           <= '0;
      chk_q           <= '0;
      pkt_par_q       <= '0;
      byte_cnt_q      <= '0;
      d_out_q         <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
      len_err_q       <= 1'b0;
      ovf_err_q       <= 1'b0;
      skid_cnt_q      <= '0;
    end else begin
      hdr_q           <= hdr_d;
      chk_q           <= chk_d;
      pkt_par_q       <= pkt_par_d;
      byte_cnt_q      <= byte_cnt_d;
      d_out_q         <= d_out_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
      len_err_q       <= len_err_d;
      ovf_err_q       <= ovf_err_d;
      skid_cnt_q      <= skid_cnt_d;
    end
  end

  // Skid storage is qualified by skid_cnt_q, so its contents need no reset.
  always_ff @(posedge clk) begin
    skid_mem_q <= skid_mem_d;
  end

  assign bus.d_out         = d_out_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
  assign bus.err           = err_q;
  assign bus.len_err       = len_err_q;
  assign bus.ovf_err       = ovf_err_q;
  assign bus.skid_empty    = skid_empty;
endmodule

// File: tb/tb_router_reg_gen.sv
module tb_router_reg_gen;
  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid, fifo_full, rst_in_reg;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic [7:0] data_in;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  router_reg_gen_if #(.DATA_W(8)) if0 ();
  router_reg_gen_if #(.DATA_W(8)) if1 ();

  assign if0.pkt_valid = pkt_valid;   assign if1.pkt_valid = pkt_valid;
  assign if0.data_in = data_in;       assign if1.data_in = data_in;
  assign if0.fifo_full = fifo_full;   assign if1.fifo_full = fifo_full;
  assign if0.rst_in_reg = rst_in_reg; assign if1.rst_in_reg = rst_in_reg;
  assign if0.detect_add = detect_add; assign if1.detect_add = detect_add;
  assign if0.lfd_state = lfd_state;   assign if1.lfd_state = lfd_state;
  assign if0.ld_state = ld_state;     assign if1.ld_state = ld_state;
  assign if0.laf_state = laf_state;   assign if1.laf_state = laf_state;
  assign if0.full_state = full_state; assign if1.full_state = full_state;

  router_reg_gen #(.DATA_W(8), .SKID_DEPTH(2), .PARITY_MODE(0)) dut0 (
    .clk(clk), .resetn(resetn), .bus(if0));
  router_reg_gen #(.DATA_W(8), .SKID_DEPTH(2), .PARITY_MODE(1)) dut1 (
    .clk(clk), .resetn(resetn), .bus(if1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0; full_state = 0;
    fifo_full = 0; rst_in_reg = 0; pkt_valid = 1; data_in = 8'h00;
  endtask

  task automatic start_pkt(input logic [7:0] h);
    clr(); detect_add = 1; data_in = h; tick();
    clr(); lfd_state = 1; tick();
    clr();
  endtask

  task automatic ld_byte(input logic pv, input logic [7:0] d, input logic ff);
    clr(); ld_state = 1; pkt_valid = pv; data_in = d; fifo_full = ff; tick();
  endtask

  task automatic soft_rst();
    clr(); rst_in_reg = 1; pkt_valid = 0; tick(); clr();
  endtask

  task automatic test_reset();
    clr(); resetn = 0; tick();
    checks++; if (if0.d_out !== 8'h00) begin errors++; $display("FAIL rst_d_out got=%h exp=00", if0.d_out); end
    checks++; if ({if0.parity_done, if0.low_pkt_valid, if0.err, if0.len_err, if0.ovf_err} !== 5'b0) begin
      errors++; $display("FAIL rst_flags got=%b exp=00000", {if0.parity_done, if0.low_pkt_valid, if0.err, if0.len_err, if0.ovf_err}); end
    checks++; if (if0.skid_empty !== 1'b1) begin errors++; $display("FAIL rst_skid_empty got=%b exp=1", if0.skid_empty); end
    checks++; if (if1.d_out !== 8'h00 || if1.skid_empty !== 1'b1) begin errors++; $display("FAIL rst_dut1 got=%h/%b exp=00/1", if1.d_out, if1.skid_empty); end
    resetn = 1;
  endtask

  // hdr 0D (len 3), payload 11 22 33, parity 0D: XOR passes, sum (0x73) fails
  task automatic test_mode0_pass();
    soft_rst();
    start_pkt(8'h0D);
    checks++; if (if0.d_out !== 8'h0D) begin errors++; $display("FAIL m0_hdr_out got=%h exp=0D", if0.d_out); end
    ld_byte(1, 8'h11, 0);
    checks++; if (if0.d_out !== 8'h11) begin errors++; $display("FAIL m0_b1 got=%h exp=11", if0.d_out); end
    ld_byte(1, 8'h22, 0);
    checks++; if (if0.d_out !== 8'h22) begin errors++; $display("FAIL m0_b2 got=%h exp=22", if0.d_out); end
    ld_byte(1, 8'h33, 0);
    checks++; if (if0.d_out !== 8'h33 || if0.parity_done !== 1'b0) begin errors++; $display("FAIL m0_b3 got=%h/%b exp=33/0", if0.d_out, if0.parity_done); end
    ld_byte(0, 8'h0D, 0);
    checks++; if (if0.d_out !== 8'h0D || if0.parity_done !== 1'b1) begin errors++; $display("FAIL m0_par got=%h/%b exp=0D/1", if0.d_out, if0.parity_done); end
    checks++; if (if0.low_pkt_valid !== 1'b1 || if0.len_err !== 1'b0) begin errors++; $display("FAIL m0_low_len got=%b/%b exp=1/0", if0.low_pkt_valid, if0.len_err); end
    checks++; if (if1.err !== 1'b0) begin errors++; $display("FAIL m1_err_early got=%b exp=0", if1.err); end
    clr(); tick();
    checks++; if (if0.err !== 1'b0) begin errors++; $display("FAIL m0_err_good got=%b exp=0", if0.err); end
    checks++; if (if1.err !== 1'b1) begin errors++; $display("FAIL m1_err_0D got=%b exp=1", if1.err); end
  endtask

  task automatic test_mode0_bad();
    soft_rst();
    start_pkt(8'h0D);
    ld_byte(1, 8'h11, 0); ld_byte(1, 8'h22, 0); ld_byte(1, 8'h33, 0);
    ld_byte(0, 8'h0E, 0);
    checks++; if (if0.err !== 1'b0 || if0.parity_done !== 1'b1) begin errors++; $display("FAIL m0_bad_edge got=%b/%b exp=0/1", if0.err, if0.parity_done); end
    clr(); tick();
    checks++; if (if0.err !== 1'b1) begin errors++; $display("FAIL m0_err_bad got=%b exp=1", if0.err); end
  endtask

  task automatic test_mode1();
    soft_rst();
    start_pkt(8'h0D);
    ld_byte(1, 8'h11, 0); ld_byte(1, 8'h22, 0); ld_byte(1, 8'h33, 0);
    ld_byte(0, 8'h73, 0);
    clr(); tick();
    checks++; if (if1.err !== 1'b0) begin errors++; $display("FAIL m1_err_good got=%b exp=0", if1.err); end
    checks++; if (if0.err !== 1'b1) begin errors++; $display("FAIL m0_err_73 got=%b exp=1", if0.err); end
  endtask

  task automatic test_skid();
    soft_rst();
    start_pkt(8'h0D);
    ld_byte(1, 8'h11, 0);
    ld_byte(1, 8'h22, 1);
    checks++; if (if0.d_out !== 8'h11 || if0.skid_empty !== 1'b0) begin errors++; $display("FAIL sk_push1 got=%h/%b exp=11/0", if0.d_out, if0.skid_empty); end
    ld_byte(1, 8'h33, 1);
    checks++; if (if0.d_out !== 8'h11 || if0.ovf_err !== 1'b0) begin errors++; $display("FAIL sk_push2 got=%h/%b exp=11/0", if0.d_out, if0.ovf_err); end
    clr(); laf_state = 1; fifo_full = 1; tick();
    checks++; if (if0.d_out !== 8'h11 || if0.skid_empty !== 1'b0) begin errors++; $display("FAIL sk_nopop_full got=%h/%b exp=11/0", if0.d_out, if0.skid_empty); end
    clr(); laf_state = 1; tick();
    checks++; if (if0.d_out !== 8'h22 || if0.skid_empty !== 1'b0) begin errors++; $display("FAIL sk_pop1 got=%h/%b exp=22/0", if0.d_out, if0.skid_empty); end
    tick();
    checks++; if (if0.d_out !== 8'h33 || if0.skid_empty !== 1'b1) begin errors++; $display("FAIL sk_pop2 got=%h/%b exp=33/1", if0.d_out, if0.skid_empty); end
    ld_byte(0, 8'h0D, 0);
    checks++; if (if0.d_out !== 8'h0D || if0.parity_done !== 1'b1 || if0.len_err !== 1'b0) begin
      errors++; $display("FAIL sk_par got=%h/%b/%b exp=0D/1/0", if0.d_out, if0.parity_done, if0.len_err); end
    clr(); tick();
    checks++; if (if0.err !== 1'b0) begin errors++; $display("FAIL sk_err got=%b exp=0", if0.err); end
  endtask

  task automatic test_ovf();
    soft_rst();
    start_pkt(8'h0D);
    ld_byte(1, 8'h11, 1);
    ld_byte(1, 8'h22, 1);
    checks++; if (if0.ovf_err !== 1'b0) begin errors++; $display("FAIL ov_before got=%b exp=0", if0.ovf_err); end
    ld_byte(1, 8'h33, 1);
    checks++; if (if0.ovf_err !== 1'b1) begin errors++; $display("FAIL ov_set got=%b exp=1", if0.ovf_err); end
    clr(); laf_state = 1; tick();
    checks++; if (if0.d_out !== 8'h11) begin errors++; $display("FAIL ov_pop1 got=%h exp=11", if0.d_out); end
    tick();
    checks++; if (if0.d_out !== 8'h22 || if0.skid_empty !== 1'b1) begin errors++; $display("FAIL ov_pop2 got=%h/%b exp=22/1", if0.d_out, if0.skid_empty); end
    checks++; if (if0.ovf_err !== 1'b1) begin errors++; $display("FAIL ov_sticky got=%b exp=1", if0.ovf_err); end
    start_pkt(8'h0D);
    checks++; if (if0.ovf_err !== 1'b0) begin errors++; $display("FAIL ov_clear got=%b exp=0", if0.ovf_err); end
  endtask

  task automatic test_len_soft();
    soft_rst();
    start_pkt(8'h11);
    ld_byte(1, 8'hAA, 0); ld_byte(1, 8'hBB, 0); ld_byte(1, 8'hCC, 0);
    ld_byte(0, 8'h5A, 0);
    checks++; if (if0.len_err !== 1'b1 || if1.len_err !== 1'b1) begin errors++; $display("FAIL len_err got=%b/%b exp=1/1", if0.len_err, if1.len_err); end
    start_pkt(8'h0D);
    ld_byte(1, 8'h11, 1);
    checks++; if (if0.skid_empty !== 1'b0 || if0.low_pkt_valid !== 1'b1) begin errors++; $display("FAIL sr_pre got=%b/%b exp=0/1", if0.skid_empty, if0.low_pkt_valid); end
    // parity byte arriving with soft reset: clear must beat set
    clr(); ld_state = 1; rst_in_reg = 1; pkt_valid = 0; data_in = 8'h99; tick();
    checks++; if (if0.low_pkt_valid !== 1'b0 || if0.skid_empty !== 1'b1) begin errors++; $display("FAIL sr_clear got=%b/%b exp=0/1", if0.low_pkt_valid, if0.skid_empty); end
  endtask

  task automatic test_priority_resetn();
    soft_rst();
    start_pkt(8'h0D);
    ld_byte(1, 8'h11, 0);
    clr(); detect_add = 1; ld_state = 1; data_in = 8'h44; tick();
    checks++; if (if0.d_out !== 8'h11) begin errors++; $display("FAIL prio_det_over_ld got=%h exp=11", if0.d_out); end
    clr(); lfd_state = 1; tick();
    checks++; if (if0.d_out !== 8'h44) begin errors++; $display("FAIL prio_hdr got=%h exp=44", if0.d_out); end
    ld_byte(1, 8'h55, 1);
    clr(); resetn = 0; tick(); resetn = 1;
    checks++; if (if0.d_out !== 8'h00 || if0.skid_empty !== 1'b1 || if0.parity_done !== 1'b0) begin
      errors++; $display("FAIL mid_resetn got=%h/%b/%b exp=00/1/0", if0.d_out, if0.skid_empty, if0.parity_done); end
    clr(); lfd_state = 1; tick();
    checks++; if (if0.d_out !== 8'h00) begin errors++; $display("FAIL mid_resetn_hdr got=%h exp=00", if0.d_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    resetn = 0;
    test_reset();
    test_mode0_pass();
    test_mode0_bad();
    test_mode1();
    test_skid();
    test_ovf();
    test_len_soft();
    test_priority_resetn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
